conv_mram_arbiter: RTL and testbench
====================================

# conv_mram_arbiter

Single-port arbiter sharing the 1024×32 conv-output MRAM between three requesters: the depthwise/pointwise conv engine (packed-nibble writes), the next-layer reader and the RISC-V host bus. Grants one single-beat transaction per cycle with round-robin fairness. An optional lock lets one requester own the port for a short burst. Read data returns on a fixed-latency, per-requester tagged valid.

## Interface
- NREQ, 3, number of requesters (0 = conv engine, 1 = next layer, 2 = host)
- ADDR_W, 10, MRAM word address width
- DATA_W, 32, MRAM word width (8 packed 4-bit activations)
- MAX_BURST, 8, maximum consecutive locked beats before forced release
- RD_LAT, 1, MRAM read latency in cycles (edges from command to dout valid)

Ports:
- clk  in  1  single clock
- rst  in  1  reset: synchronous, active-high
- req_valid  in  NREQ  request present, held until granted
- req_lock  in  NREQ  request burst ownership
- req_we  in  4·NREQ  byte write enables; 0000 = read
- req_addr  in  ADDR_W·NREQ  word address
- req_wdata  in  DATA_W·NREQ  write data
- req_gnt  out  NREQ  one-hot, combinational; transfer occurs at the edge where req_valid[i] & req_gnt[i]
- rsp_valid  out  NREQ  one-hot read-data valid, registered
- rsp_rdata  out  DATA_W  read data, valid when any rsp_valid bit is set
- mem_en, mem_we (4), mem_addr (ADDR_W), mem_din (DATA_W)  out  registered MRAM command
- mem_dout  in  DATA_W  MRAM read data
- busy  out  1  high while the arbiter is in LOCKED or any read is in flight

## Operation
- States: IDLE (no owner) and LOCKED (owner = lock_id).
- IDLE arbitration:
  - Winner is the first requester with req_valid=1, scanning from rr_ptr upward modulo NREQ.
  - req_gnt is one-hot to the winner; all zeros if no request.
- Transfer at the edge:
  - Register mem_en=1, mem_we/addr/din from the winner.
  - rr_ptr ← winner+1 (mod NREQ).
  - If the winner's req_lock=1 and MAX_BURST>1: enter LOCKED, lock_id ← winner, beat_cnt ← 1.
- LOCKED:
  - Only lock_id may be granted; others see gnt=0.
  - Each transfer increments beat_cnt.
  - Return to IDLE when any of these holds:
    - lock_id transfers with req_lock=0;
    - beat_cnt reaches MAX_BURST (that transfer still completes);
    - lock_id's req_valid is low for a cycle. No beat is issued that cycle.
  - On return to IDLE, rr_ptr = lock_id+1.
- No-transfer cycles: mem_en=0, mem_we=0; mem_addr/din hold their last values.
- Reads (req_we=0000): the one-hot tag enters a RD_LAT-deep shift register timed from mem_en. rsp_valid[i] = tag output; rsp_rdata = mem_dout (pass-through).
- Writes produce no response.
- Back-to-back reads from different requesters pipeline at full rate. Tags never collide because one command issues per cycle.
- Reset (rst=1 at an edge):
  - Cleared to 0: mem_en, mem_we, mem_addr, mem_din, rsp_valid, busy, tag pipe, rr_ptr, beat_cnt, lock_id.
  - State → IDLE.
  - In-flight reads are dropped; no rsp_valid follows reset.
  - req_gnt is forced to 0 while rst=1.

## Timing
- Transfer edge E → mem command visible in cycle E+1.
- Read data and rsp_valid are visible RD_LAT edges after that: with RD_LAT=1, in the cycle following edge E+1.
- Throughput: 1 transaction per cycle sustained. A single requester with req_valid held continuously is granted every cycle if it is the only one requesting.
- Fairness: with all NREQ requesting and no locks, each requester is granted exactly once per NREQ cycles.
- A requester that loses must hold req_* stable; gnt may arrive any later cycle.
- Simultaneous lock release and a new request from another requester: the release edge completes; the new requester can win in the next cycle.
- Worst-case wait for a requester: (NREQ−1)·MAX_BURST cycles.

## Structure
- Package cnn_mram_pkg holds:
  - ADDR_W, DATA_W;
  - requester IDs REQ_CONV=0, REQ_NEXT=1, REQ_HOST=2;
  - state enum {IDLE, LOCKED}.
- Sub-module rr_pick: combinational rotate-priority picker (req vector, pointer → one-hot winner plus index). It is reused by the later layer-scheduler arbiters.

## Test plan
- Single read: host reads addr 0x05 after writing 0xA5A5_1234 → rsp_valid[2] two cycles after the transfer edge, rsp_rdata=0xA5A5_1234; rsp_valid[0:1] stay 0.
- Round-robin: all three hold reads from reset → grants in order 0,1,2,0,1,2; rsp_valid bits follow the same order, with a 2-cycle offset between grant and rsp_valid.
- Lock burst: conv engine locks 12 writes (addr 0..11) while host requests → conv gets beats 1–8, host granted at beat 9, conv resumes afterwards; MRAM contents are correct.
- Early release: conv locks, then drops req_valid after 3 beats → state IDLE next cycle, rr_ptr=1, next-layer reader granted immediately.
- Byte enables: write 0xFFFF_FFFF, then we=0011 data 0 → readback 0xFFFF_0000.
- Reset mid-read: rst asserted the cycle after a read transfer → no rsp_valid, all outputs 0, first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/cnn_mram_pkg.sv
// Shared types and constants for the conv-output MRAM arbiter.
// Word geometry, requester IDs and arbiter state encoding.
package cnn_mram_pkg;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  localparam int REQ_CONV = 0;
  localparam int REQ_NEXT = 1;
  localparam int REQ_HOST = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;
endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: first set request at or above the pointer.
// Returns a one-hot winner and its index; all zeros when nothing requests.
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx
);
  int w_j;

  // Scan from the farthest offset down so the nearest request wins last.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    w_j   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= N) w_j = w_j - N;
      if (i_req[w_j]) begin
        o_gnt      = '0;
        o_gnt[w_j] = 1'b1;
        o_idx      = PW'(w_j);
      end
    end
  end
endmodule

// File: rtl/conv_mram_arbiter.sv
// Single-port MRAM arbiter: round-robin grants, short locked bursts,
// fixed-latency tagged read responses.
module conv_mram_arbiter
  import cnn_mram_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int ADDR_W    = cnn_mram_pkg::ADDR_W,
  parameter int DATA_W    = cnn_mram_pkg::DATA_W,
  parameter int MAX_BURST = 8,
  parameter int RD_LAT    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_lock,
  input  logic [4*NREQ-1:0]        req_we,
  input  logic [ADDR_W*NREQ-1:0]   req_addr,
  input  logic [DATA_W*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_gnt,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     mem_en,
  output logic [3:0]               mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_din,
  input  logic [DATA_W-1:0]        mem_dout,
  output logic                     busy
);
  localparam int PW = $clog2(NREQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_e                   r_state;
  logic [PW-1:0]                r_rr_ptr;
  logic [PW-1:0]                r_lock_id;
  logic [BW-1:0]                r_beat_cnt;
  logic                         r_mem_en;
  logic [3:0]                   r_mem_we;
  logic [ADDR_W-1:0]            r_mem_addr;
  logic [DATA_W-1:0]            r_mem_din;
  logic [NREQ-1:0]              r_cmd_tag;
  logic [RD_LAT-1:0][NREQ-1:0]  r_pipe;

  logic [NREQ-1:0]    w_pick_gnt;
  logic [PW-1:0]      w_pick_idx;
  logic [NREQ-1:0]    w_gnt;
  logic [PW-1:0]      w_win;
  logic [PW-1:0]      w_nxt_ptr;
  logic               w_xfer;
  logic               w_lock;
  logic [3:0]         w_we;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_din;
  logic               w_inflight;

  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx)
  );

  // While locked only the owner can be granted, and only if it asks.
  always_comb begin
    w_gnt = '0;
    w_win = w_pick_idx;
    if (!rst) begin
      if (r_state == IDLE) begin
        w_gnt = w_pick_gnt;
      end else begin
        w_win            = r_lock_id;
        w_gnt[r_lock_id] = req_valid[r_lock_id];
      end
    end
  end

  always_comb begin
    w_we   = '0;
    w_addr = '0;
    w_din  = '0;
    w_lock = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (PW'(i) == w_win) begin
        w_we   = req_we[4*i +: 4];
        w_addr = req_addr[ADDR_W*i +: ADDR_W];
        w_din  = req_wdata[DATA_W*i +: DATA_W];
        w_lock = req_lock[i];
      end
    end
  end

  assign w_xfer    = |w_gnt;
  assign w_nxt_ptr = (int'(w_win) == NREQ - 1) ? '0 : w_win + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_lock_id  <= '0;
      r_beat_cnt <= '0;
      r_mem_en   <= 1'b0;
      r_mem_we   <= '0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_cmd_tag  <= '0;
      r_pipe     <= '0;
    end else begin
      r_mem_en <= w_xfer;
      r_mem_we <= w_xfer ? w_we : 4'b0;
      if (w_xfer) begin
        r_mem_addr <= w_addr;
        r_mem_din  <= w_din;
      end
      r_cmd_tag <= (w_xfer && w_we == 4'b0) ? w_gnt : '0;
      r_pipe[0] <= r_cmd_tag;
      for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];

      unique case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_rr_ptr <= w_nxt_ptr;
            if (w_lock && MAX_BURST > 1) begin
              r_state    <= LOCKED;
              r_lock_id  <= w_win;
              r_beat_cnt <= BW'(1);
            end
          end
        end
        LOCKED: begin
          if (!w_xfer) begin
            r_state  <= IDLE;
            r_rr_ptr <= w_nxt_ptr;
          end else begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            if (!w_lock || r_beat_cnt == BW'(MAX_BURST - 1)) begin
              r_state  <= IDLE;
              r_rr_ptr <= w_nxt_ptr;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The final pipe stage is the response itself, not an in-flight read.
  always_comb begin
    w_inflight = |r_cmd_tag;
    for (int i = 0; i < RD_LAT - 1; i++) w_inflight = w_inflight | (|r_pipe[i]);
  end

  assign req_gnt   = w_gnt;
  assign rsp_valid = r_pipe[RD_LAT-1];
  assign rsp_rdata = mem_dout;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_din   = r_mem_din;
  assign busy      = (r_state == LOCKED) | w_inflight;
endmodule

// File: tb/tb_conv_mram_arbiter.sv
// Bench for conv_mram_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transaction-level reference model.
module tb_conv_mram_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_lock;
  logic [3:0]  t_we   [3];
  logic [9:0]  t_addr [3];
  logic [31:0] t_wd   [3];
  logic [11:0] req_we;
  logic [29:0] req_addr;
  logic [95:0] req_wdata;
  logic [2:0]  req_gnt;
  logic [2:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        busy;

  assign req_we    = {t_we[2], t_we[1], t_we[0]};
  assign req_addr  = {t_addr[2], t_addr[1], t_addr[0]};
  assign req_wdata = {t_wd[2], t_wd[1], t_wd[0]};

  conv_mram_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_lock  (req_lock),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_gnt   (req_gnt),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .busy      (busy)
  );

  // MRAM device, one-cycle read latency; bench only uses the low 64 words.
  logic [31:0] mram [64];
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 64; k++) mram[k] <= '0;
    end else if (mem_en) begin
      if (|mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_we[b]) mram[mem_addr[5:0]][8*b +: 8] <= mem_din[8*b +: 8];
      end else begin
        mem_dout <= mram[mem_addr[5:0]];
      end
    end
  end

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          due;
    int          id;
    logic [31:0] data;
  } rsp_t;

  rsp_t        rq[$];
  logic [31:0] ref_mem [64];
  int          m_owner, m_ptr, m_beats, m_win, cyc;
  logic        e_en;
  logic [3:0]  e_we;
  logic [9:0]  e_addr;
  logic [31:0] e_din;
  logic [2:0]  last_gnt;
  logic [31:0] last_rd;

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_beats = 0;
    rq.delete();
    e_en   = 1'b0;
    e_we   = '0;
    e_addr = '0;
    e_din  = '0;
    for (int k = 0; k < 64; k++) ref_mem[k] = '0;
  endtask

  task automatic release_lock();
    m_ptr   = (m_owner + 1) % 3;
    m_owner = -1;
  endtask

  // Called at a falling edge with this cycle's inputs applied.
  task automatic tick();
    logic [2:0] eg;
    logic       eb;
    #1;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      chk("rsp_valid", 32'(rsp_valid), 32'(3'b001 << rq[0].id));
      chk("rsp_rdata", rsp_rdata, rq[0].data);
      last_rd = rsp_rdata;
      void'(rq.pop_front());
    end else begin
      chk("rsp_idle", 32'(rsp_valid), 32'd0);
    end
    chk("mem_en", 32'(mem_en), 32'(e_en));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("mem_din", mem_din, e_din);
    eb = (m_owner >= 0) || (rq.size() > 0 && rq[0].due == cyc + 1);
    chk("busy", 32'(busy), 32'(eb));

    m_win = -1;
    if (!rst) begin
      if (m_owner < 0) begin
        for (int k = 0; k < 3; k++) begin
          int j;
          j = (m_ptr + k) % 3;
          if (req_valid[j] && m_win < 0) m_win = j;
        end
      end else if (req_valid[m_owner]) begin
        m_win = m_owner;
      end
    end
    eg = (m_win >= 0) ? 3'(1 << m_win) : 3'b000;
    chk("gnt", 32'(req_gnt), 32'(eg));
    last_gnt = req_gnt;

    if (rst) begin
      model_reset();
    end else begin
      e_en = (m_win >= 0);
      e_we = '0;
      if (m_win >= 0) begin
        e_we   = t_we[m_win];
        e_addr = t_addr[m_win];
        e_din  = t_wd[m_win];
        if (e_we == 4'b0) begin
          rq.push_back('{cyc + 2, m_win, ref_mem[e_addr[5:0]]});
        end else begin
          for (int b = 0; b < 4; b++)
            if (e_we[b]) ref_mem[e_addr[5:0]][8*b +: 8] = e_din[8*b +: 8];
        end
      end
      if (m_owner < 0) begin
        if (m_win >= 0) begin
          m_ptr = (m_win + 1) % 3;
          if (req_lock[m_win]) begin
            m_owner = m_win;
            m_beats = 1;
          end
        end
      end else if (m_win >= 0) begin
        m_beats++;
        if (!req_lock[m_owner] || m_beats == 8) release_lock();
      end else begin
        release_lock();
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic set_req(input int i, input logic v, input logic l,
                         input logic [3:0] we, input logic [9:0] a,
                         input logic [31:0] d);
    req_valid[i] = v;
    req_lock[i]  = l;
    t_we[i]      = we;
    t_addr[i]    = a;
    t_wd[i]      = d;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    req_lock = '0;
    for (int k = 0; k < 20 && req_valid != 3'b0; k++) begin
      tick();
      req_valid = req_valid & ~last_gnt;
    end
    chk("drain", 32'(req_valid), 32'd0);
    req_valid = '0;
    repeat (3) tick();
  endtask

  initial begin
    int conv_n, host_at, guard, n;
    logic host_pend;
    logic pend [3];

    rst       = 1'b1;
    req_valid = '0;
    req_lock  = '0;
    for (int i = 0; i < 3; i++) set_req(i, 1'b0, 1'b0, 4'h0, 10'd0, 32'd0);
    last_rd  = '0;
    last_gnt = '0;
    cyc      = 0;
    repeat (2) @(negedge clk);
    model_reset();
    tick();
    rst = 1'b0;

    // single host write then read
    set_req(2, 1'b1, 1'b0, 4'hF, 10'd5, 32'hA5A5_1234);
    tick();
    set_req(2, 1'b1, 1'b0, 4'h0, 10'd5, 32'd0);
    tick();
    req_valid = '0;
    repeat (3) tick();
    chk("single_rd", last_rd, 32'hA5A5_1234);

    // byte enables
    set_req(0, 1'b1, 1'b0, 4'hF, 10'd6, 32'hFFFF_FFFF);
    tick();
    set_req(0, 1'b1, 1'b0, 4'b0011, 10'd6, 32'd0);
    tick();
    set_req(0, 1'b1, 1'b0, 4'h0, 10'd6, 32'd0);
    tick();
    req_valid = '0;
    repeat (3) tick();
    chk("byte_en_rd", last_rd, 32'hFFFF_0000);

    // round robin from reset
    reset_dut();
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b0, 4'h0, 10'(i), 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rr_order", 32'(last_gnt), 32'(3'b001 << (k % 3)));
    end
    drain();

    // locked burst of 12 conv writes against a waiting host
    reset_dut();
    conv_n    = 0;
    host_pend = 1'b1;
    host_at   = -1;
    guard     = 0;
    while ((conv_n < 12 || host_pend) && guard < 60) begin
      set_req(0, 1'(conv_n < 12), 1'b1, 4'hF, 10'(conv_n), 32'h1000 + conv_n);
      set_req(2, host_pend, 1'b0, 4'h0, 10'd5, 32'd0);
      tick();
      guard++;
      if (last_gnt[0]) conv_n++;
      if (last_gnt[2]) begin
        host_pend = 1'b0;
        host_at   = conv_n;
      end
    end
    chk("lock_timeout", 32'(guard < 60), 32'd1);
    chk("lock_host_at", 32'(host_at), 32'd8);
    req_valid = '0;
    req_lock  = '0;
    tick();
    for (int k = 0; k < 12; k++) begin
      set_req(1, 1'b1, 1'b0, 4'h0, 10'(k), 32'd0);
      tick();
    end
    req_valid = '0;
    repeat (3) tick();
    chk("lock_last_rd", last_rd, 32'h1000 + 11);

    // early release after three locked beats
    reset_dut();
    set_req(1, 1'b1, 1'b0, 4'h0, 10'd0, 32'd0);
    n     = 0;
    guard = 0;
    while (n < 3 && guard < 10) begin
      set_req(0, 1'b1, 1'b1, 4'hF, 10'(20 + n), 32'hBEEF_0000 + n);
      tick();
      guard++;
      if (last_gnt[0]) n++;
    end
    chk("early_beats", 32'(n), 32'd3);
    req_valid[0] = 1'b0;
    set_req(2, 1'b1, 1'b0, 4'h0, 10'd1, 32'd0);
    tick();
    chk("rel_gap", 32'(last_gnt), 32'd0);
    tick();
    chk("rel_next", 32'(last_gnt), 32'b010);
    req_valid = req_valid & ~last_gnt;
    drain();

    // reset one cycle after a read transfer
    set_req(2, 1'b1, 1'b0, 4'h0, 10'd5, 32'd0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b0, 4'h0, 10'(i), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_rsp", 32'(rsp_valid), 32'd0);
    chk("rst_en", 32'(mem_en), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    chk("rst_first", 32'(last_gnt), 32'b001);
    req_valid = req_valid & ~last_gnt;
    drain();

    // random traffic
    for (int i = 0; i < 3; i++) pend[i] = 1'b0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] && $urandom_range(0, 9) < 6) begin
          logic [3:0] we;
          int r;
          r = $urandom_range(0, 3);
          we = (r < 2) ? 4'h0 : (r == 2) ? 4'hF : 4'($urandom_range(1, 15));
          pend[i] = 1'b1;
          set_req(i, 1'b1, 1'($urandom_range(0, 2) == 0), we,
                  10'($urandom_range(0, 15)), $urandom);
        end
        req_valid[i] = pend[i];
      end
      tick();
      for (int i = 0; i < 3; i++) if (last_gnt[i]) pend[i] = 1'b0;
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
